// File: rtl/hamming_uart_pkg.sv
// Shared types and helpers for the Hamming-protected UART transmitter.
package hamming_uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_PAR, U_STOP} uart_state_e;
  typedef enum logic {S_IDLE, S_SPLIT} seq_state_e;

  // Hamming(7,4) code word; bit7 optionally carries overall parity for SECDED.
  function automatic logic [7:0] ham74_enc(input logic [3:0] d, input logic secded);
    logic       p1, p2, p3;
    logic [6:0] code;
    p1   = d[0] ^ d[1] ^ d[3];
    p2   = d[0] ^ d[2] ^ d[3];
    p3   = d[1] ^ d[2] ^ d[3];
    code = {d[3], d[2], d[1], p3, d[0], p2, p1};
    return {secded & (^code), code};
  endfunction

endpackage

// File: rtl/hamming_uart_tx_sync_fifo.sv
// Synchronous FIFO with registered occupancy count and synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign rdata_c = mem[rd_ptr];
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/hamming_uart_tx.sv
// Splits words into nibbles, Hamming-encodes them, buffers the bytes and sends UART frames.
module hamming_uart_tx
  import hamming_uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SECDED       = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned NIBS  = DATA_W / 4;
  localparam int unsigned NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  seq_state_e        seq_q, seq_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [NIB_W-1:0]  nib_q, nib_d;
  logic              in_ready_d;
  logic              push;
  logic [3:0]        nib_data;
  logic [7:0]        push_byte;

  uart_state_e       u_q, u_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [7:0]        data_q, data_d;
  logic              pop;
  logic              bit_end;
  logic              par_bit;
  logic              tx_d, busy_d;

  logic [7:0]        fifo_rdata_c;
  logic              fifo_full_c, fifo_empty_c;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clr),
    .push    (push),
    .pop     (pop),
    .wdata   (push_byte),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level   (fifo_level)
  );

  assign nib_data  = 4'(word_q >> {nib_q, 2'b00});
  assign push_byte = ham74_enc(nib_data, SECDED != 0);
  assign bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign par_bit   = (^data_q) ^ (PARITY == PAR_ODD);

  // State and registered-output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q    <= S_IDLE;
      word_q   <= '0;
      nib_q    <= '0;
      in_ready <= 1'b1;
      u_q      <= U_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      seq_q    <= seq_d;
      word_q   <= word_d;
      nib_q    <= nib_d;
      in_ready <= in_ready_d;
      u_q      <= u_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      tx       <= tx_d;
      tx_busy  <= busy_d;
    end
  end

  // Sequencer next state: a push into a full FIFO waits regardless of a same-cycle pop.
  always_comb begin
    seq_d  = seq_q;
    word_d = word_q;
    nib_d  = nib_q;
    if (clr) begin
      seq_d = S_IDLE;
    end else begin
      case (seq_q)
        S_IDLE: if (in_valid && in_ready) begin
          word_d = in_data;
          nib_d  = '0;
          seq_d  = S_SPLIT;
        end
        S_SPLIT: if (!fifo_full_c) begin
          if (nib_q == NIB_W'(NIBS - 1)) seq_d = S_IDLE;
          else                           nib_d = nib_q + 1'b1;
        end
        default: seq_d = S_IDLE;
      endcase
    end
  end

  // UART next state, baud timing and FIFO pop.
  always_comb begin
    u_d    = u_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    stop_d = stop_q;
    data_d = data_q;
    pop    = 1'b0;
    if (clr) begin
      u_d   = U_IDLE;
      cnt_d = '0;
    end else if (u_q == U_IDLE) begin
      if (!fifo_empty_c) begin
        pop    = 1'b1;
        data_d = fifo_rdata_c;
        cnt_d  = '0;
        u_d    = U_START;
      end
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      if (bit_end) begin
        case (u_q)
          U_START: begin
            u_d   = U_DATA;
            bit_d = '0;
          end
          U_DATA: begin
            if (bit_q == 3'd7) begin
              u_d    = (PARITY != PAR_NONE) ? U_PAR : U_STOP;
              stop_d = 1'b0;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          U_PAR: begin
            u_d    = U_STOP;
            stop_d = 1'b0;
          end
          U_STOP: begin
            if (stop_q == 1'(STOP_BITS - 1)) begin
              if (!fifo_empty_c) begin
                pop    = 1'b1;
                data_d = fifo_rdata_c;
                u_d    = U_START;
              end else begin
                u_d = U_IDLE;
              end
            end else begin
              stop_d = 1'b1;
            end
          end
          default: u_d = U_IDLE;
        endcase
      end
    end
  end

  // Outputs for the next cycle, decoded from next state.
  always_comb begin
    in_ready_d = (seq_d == S_IDLE);
    push       = !clr && (seq_q == S_SPLIT) && !fifo_full_c;
    tx_d       = 1'b1;
    busy_d     = 1'b0;
    case (u_d)
      U_START: begin tx_d = 1'b0;          busy_d = 1'b1; end
      U_DATA:  begin tx_d = data_d[bit_d]; busy_d = 1'b1; end
      U_PAR:   begin tx_d = par_bit;       busy_d = 1'b1; end
      U_STOP:  begin tx_d = 1'b1;          busy_d = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Directed bench for hamming_uart_tx: three parameterisations share clock, reset and clr.
module tb_hamming_uart_tx;

  typedef struct {
    int         sel;
    int         t;
    logic [7:0] data;
    logic       par;
    logic       ok;
  } frame_t;

  logic       clk, rst_n, clr;
  logic       vld_a, vld_b, vld_c;
  logic [7:0] dat_a, dat_b, dat_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] lvl_a, lvl_b, lvl_c;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int low_a = 0;
  int max_lvl = 0;
  bit stall_seen = 0;
  frame_t fq[$];
  logic [7:0] exp_burst [8] = '{8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4, 8'h4B};

  hamming_uart_tx #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(16), .PARITY(0),
                    .STOP_BITS(1), .SECDED(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(vld_a), .in_ready(rdy_a),
    .in_data(dat_a), .tx(tx_a), .tx_busy(busy_a), .fifo_level(lvl_a));

  hamming_uart_tx #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY(2),
                    .STOP_BITS(2), .SECDED(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(vld_b), .in_ready(rdy_b),
    .in_data(dat_b), .tx(tx_b), .tx_busy(busy_b), .fifo_level(lvl_b));

  hamming_uart_tx #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY(1),
                    .STOP_BITS(1), .SECDED(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(vld_c), .in_ready(rdy_c),
    .in_data(dat_c), .tx(tx_c), .tx_busy(busy_c), .fifo_level(lvl_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_a === 1'b0) low_a <= low_a + 1;
  end

  function automatic logic cur_tx(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic cur_rdy(input int sel);
    case (sel)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Passive UART receiver: samples mid-bit on falling clock edges.
  task automatic mon(input int sel, input int cpb, input bit has_par, input int stops);
    frame_t     f;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (cur_tx(sel) === 1'b0) begin
        f.sel = sel; f.t = cyc; f.ok = 1'b1; f.par = 1'b0;
        repeat (cpb / 2) @(negedge clk);
        if (cur_tx(sel) !== 1'b0) f.ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (cpb) @(negedge clk);
          d[i] = cur_tx(sel);
        end
        f.data = d;
        if (has_par) begin
          repeat (cpb) @(negedge clk);
          f.par = cur_tx(sel);
        end
        for (int s = 0; s < stops; s++) begin
          repeat (cpb) @(negedge clk);
          if (cur_tx(sel) !== 1'b1) f.ok = 1'b0;
        end
        fq.push_back(f);
      end
    end
  endtask

  initial mon(0, 16, 1'b0, 1);
  initial mon(1, 4, 1'b1, 2);
  initial mon(2, 4, 1'b1, 1);

  task automatic get_frame(input int sel, output frame_t f);
    int n = 0;
    bit got = 1'b0;
    f.sel = -1; f.t = 0; f.data = '0; f.par = 1'b0; f.ok = 1'b0;
    while (!got && n < 3000) begin
      for (int i = 0; i < fq.size(); i++) begin
        if (!got && fq[i].sel == sel) begin
          f = fq[i];
          fq.delete(i);
          got = 1'b1;
        end
      end
      if (!got) begin
        @(negedge clk);
        n++;
      end
    end
    chk($sformatf("frame_arrival_%0d", sel), 32'(got), 32'd1);
  endtask

  // Leaves in_valid high after the accepting edge so back-to-back words can follow.
  task automatic send(input int sel, input logic [7:0] d);
    int n = 0;
    case (sel)
      0:       begin vld_a = 1'b1; dat_a = d; end
      1:       begin vld_b = 1'b1; dat_b = d; end
      default: begin vld_c = 1'b1; dat_c = d; end
    endcase
    while (cur_rdy(sel) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (sel == 0) begin
        if (int'(lvl_a) > max_lvl) max_lvl = int'(lvl_a);
        if (vld_a && !rdy_a && lvl_a == 3'd4) stall_seen = 1'b1;
      end
    end
    chk("send_ready_wait", 32'(n < 2000), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    frame_t f0, f1;
    int     t_prev, low0;
    rst_n = 1'b0; clr = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
    dat_a = '0; dat_b = '0; dat_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(rdy_a), 32'd1);
    chk("rst_level", 32'(lvl_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xB0: bytes 0x00 then 0x55, first start bit two edges after acceptance.
    send(0, 8'hB0);
    vld_a = 1'b0;
    chk("lat_e0_tx", 32'(tx_a), 32'd1);
    chk("lat_e0_ready", 32'(rdy_a), 32'd0);
    @(negedge clk);
    chk("lat_e1_tx", 32'(tx_a), 32'd1);
    chk("lat_e1_level", 32'(lvl_a), 32'd1);
    @(negedge clk);
    chk("lat_e2_tx", 32'(tx_a), 32'd0);
    chk("lat_e2_busy", 32'(busy_a), 32'd1);
    get_frame(0, f0);
    get_frame(0, f1);
    chk("b0_byte0", 32'(f0.data), 32'h00);
    chk("b0_byte1", 32'(f1.data), 32'h55);
    chk("b0_framing", 32'({f0.ok, f1.ok}), 32'd3);
    chk("b0_frame_len", 32'(f1.t - f0.t), 32'd160);
    repeat (20) @(negedge clk);
    chk("b0_idle_busy", 32'(busy_a), 32'd0);
    chk("b0_idle_tx", 32'(tx_a), 32'd1);

    // 0xFF with SECDED: two 0xFF bytes.
    send(0, 8'hFF);
    vld_a = 1'b0;
    get_frame(0, f0);
    get_frame(0, f1);
    chk("ff_byte0", 32'(f0.data), 32'hFF);
    chk("ff_byte1", 32'(f1.data), 32'hFF);

    // Odd parity, two stop bits (dut_b) and even parity, no SECDED (dut_c).
    send(1, 8'hB0);
    vld_b = 1'b0;
    send(2, 8'hB0);
    vld_c = 1'b0;
    get_frame(1, f0);
    get_frame(1, f1);
    chk("odd_byte0", 32'(f0.data), 32'h00);
    chk("odd_byte1", 32'(f1.data), 32'h55);
    chk("odd_par0", 32'(f0.par), 32'd1);
    chk("odd_par1", 32'(f1.par), 32'd1);
    chk("odd_stop2_ok", 32'({f0.ok, f1.ok}), 32'd3);
    chk("odd_frame_len", 32'(f1.t - f0.t), 32'd48);
    get_frame(2, f0);
    get_frame(2, f1);
    chk("even_byte1", 32'(f1.data), 32'h55);
    chk("even_par1", 32'(f1.par), 32'd0);
    chk("even_frame_len", 32'(f1.t - f0.t), 32'd44);
    send(2, 8'hFF);
    vld_c = 1'b0;
    get_frame(2, f0);
    get_frame(2, f1);
    chk("nosecded_byte0", 32'(f0.data), 32'h7F);
    chk("nosecded_byte1", 32'(f1.data), 32'h7F);
    chk("even_par_7f", 32'(f0.par), 32'd1);
    fq.delete();

    // Burst of four words with in_valid held: FIFO saturates, eight frames back-to-back.
    max_lvl = 0;
    stall_seen = 1'b0;
    send(0, 8'h21);
    send(0, 8'h43);
    send(0, 8'h65);
    send(0, 8'h87);
    vld_a = 1'b0;
    chk("burst_max_level", 32'(max_lvl), 32'd4);
    chk("burst_stall", 32'(stall_seen), 32'd1);
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      get_frame(0, f0);
      chk($sformatf("burst_byte%0d", i), 32'(f0.data), 32'(exp_burst[i]));
      if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(f0.t - t_prev), 32'd160);
      t_prev = f0.t;
    end
    repeat (20) @(negedge clk);
    chk("burst_drained", 32'(lvl_a), 32'd0);

    // clr mid-DATA with three bytes queued.
    send(0, 8'h21);
    send(0, 8'h43);
    vld_a = 1'b0;
    repeat (30) @(negedge clk);
    chk("clr_pre_level", 32'(lvl_a), 32'd3);
    chk("clr_pre_busy", 32'(busy_a), 32'd1);
    clr = 1'b1; vld_a = 1'b1; dat_a = 8'h99;
    @(negedge clk);
    clr = 1'b0; vld_a = 1'b0;
    chk("clr_tx", 32'(tx_a), 32'd1);
    chk("clr_busy", 32'(busy_a), 32'd0);
    chk("clr_level", 32'(lvl_a), 32'd0);
    chk("clr_ready", 32'(rdy_a), 32'd1);
    low0 = low_a;
    repeat (400) @(negedge clk);
    chk("clr_no_frames", 32'(low_a - low0), 32'd0);
    chk("clr_level_stays", 32'(lvl_a), 32'd0);
    fq.delete();

    // Asynchronous reset in the middle of an all-zero data byte.
    send(0, 8'hB0);
    vld_a = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_mid_pre_tx", 32'(tx_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_async", 32'(tx_a), 32'd1);
    chk("rst_mid_busy_async", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    low0 = low_a;
    repeat (400) @(negedge clk);
    chk("rst_mid_no_resume", 32'(low_a - low0), 32'd0);
    chk("rst_mid_ready", 32'(rdy_a), 32'd1);
    chk("rst_mid_level", 32'(lvl_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
